spi_ram_responder: RTL

SPI mode-0 target that models the external serial RAM addressed by the memory bus's SPI controller (RAM chip-select path). It decodes READ (0x03) and WRITE (0x02) commands with a 3-byte address, serves burst reads and writes from an internal byte array, and is used as the RAM-side end of the SPI link in system benches and FPGA bring-up.

---
 rtl/spi_ram_responder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 serial RAM target. Decodes READ (0x03) and
// WRITE (0x02) with a multi-byte address and serves burst accesses from an
// internal byte array. All SPI pins are oversampled in the clk domain.
module spi_ram_responder #(
    parameter int DEPTH      = 256,
    parameter int ADDR_BYTES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic busy,
    output logic cmd_err
);
    localparam int AW  = $clog2(DEPTH);
    localparam int BCW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [BCW-1:0] LAST_ADDR_BYTE = BCW'(ADDR_BYTES - 1);
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    // Synchronizer reset values for {mosi, cs_n, sclk}: cs_n idles high so a
    // released reset does not look like a chip-select assertion.
    localparam logic [2:0] SYNC_RESET = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        WRITE  = 3'd3,
        READ   = 3'd4,
        IGNORE = 3'd5
    } state_t;

    logic [2:0]     pins;
    logic [2:0]     meta;
    logic [2:0]     sync;
    logic           sclk_prev;
    logic           sclk_sync;
    logic           cs_sync;
    logic           mosi_sync;
    logic           sclk_rise;
    logic           sclk_fall;

    state_t         state;
    logic [2:0]     bit_cnt;
    logic [BCW-1:0] byte_cnt;
    logic [7:0]     shift_in;
    logic [7:0]     rx_byte;
    logic [AW-1:0]  addr;
    logic [7:0]     tx;
    logic           is_read;
    logic           fetch_req;
    logic           fetch_load;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [7:0]     wr_data;
    logic [7:0]     rd_data;
    logic [7:0]     mem [DEPTH];

    assign pins      = {mosi, cs_n, sclk};
    assign sclk_sync = sync[0];
    assign cs_sync   = sync[1];
    assign mosi_sync = sync[2];
    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;
    // Byte completed by the bit arriving on this rise
    assign rx_byte   = {shift_in[6:0], mosi_sync};

    // Two-flop synchronizers for the SPI pins plus sclk history for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= SYNC_RESET;
            sync      <= SYNC_RESET;
            sclk_prev <= 1'b0;
        end else begin
            meta      <= pins;
            sync      <= meta;
            sclk_prev <= sclk_sync;
        end
    end

    // Byte storage: registered read of the current address, committed writes
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[addr];
    end

    // Protocol FSM with registered outputs. A read fetch is a two-cycle
    // pipeline: fetch_req lets rd_data settle on the final address, then
    // fetch_load moves it into the tx shifter and advances the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shift_in   <= '0;
            addr       <= '0;
            tx         <= '0;
            is_read    <= 1'b0;
            fetch_req  <= 1'b0;
            fetch_load <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            miso       <= 1'b0;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            fetch_req  <= 1'b0;
            fetch_load <= fetch_req;
            if (fetch_load) begin
                tx   <= rd_data;
                addr <= addr + 1'b1;
            end

            if (state != IDLE && cs_sync) begin
                // Deselect aborts everything; an unfinished write byte is dropped
                state      <= IDLE;
                busy       <= 1'b0;
                miso       <= 1'b0;
                bit_cnt    <= '0;
                byte_cnt   <= '0;
                fetch_load <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        miso <= 1'b0;
                        if (!cs_sync) begin
                            state    <= CMD;
                            busy     <= 1'b1;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                        end
                    end

                    CMD: begin
                        if (sclk_rise) begin
                            shift_in <= rx_byte;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                if (rx_byte == CMD_READ) begin
                                    is_read <= 1'b1;
                                    cmd_err <= 1'b0;
                                    state   <= ADDR;
                                end else if (rx_byte == CMD_WRITE) begin
                                    is_read <= 1'b0;
                                    cmd_err <= 1'b0;
                                    state   <= ADDR;
                                end else begin
                                    cmd_err <= 1'b1;
                                    state   <= IGNORE;
                                end
                            end
                        end
                    end

                    ADDR: begin
                        // Shifting every address bit through an AW-bit register
                        // leaves exactly the low AW bits; upper bits fall off.
                        if (sclk_rise) begin
                            addr    <= {addr[AW-2:0], mosi_sync};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 1'b1;
                                if (byte_cnt == LAST_ADDR_BYTE) begin
                                    byte_cnt <= '0;
                                    if (is_read) begin
                                        fetch_req <= 1'b1;
                                        state     <= READ;
                                    end else begin
                                        state <= WRITE;
                                    end
                                end
                            end
                        end
                    end

                    WRITE: begin
                        if (sclk_rise) begin
                            shift_in <= rx_byte;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= rx_byte;
                                addr    <= addr + 1'b1;
                            end
                        end
                    end

                    READ: begin
                        // Address already points at the next byte after each load
                        if (sclk_fall) begin
                            miso    <= tx[7];
                            tx      <= {tx[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                fetch_req <= 1'b1;
                            end
                        end
                    end

                    IGNORE: begin
                        miso <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        miso  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
